// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the register file's single write port between NREQ writeback
//   requesters using round-robin arbitration with a valid/ready handshake.
//   It also keeps a 16-entry pending scoreboard. The issue stage sets an entry
//   when it claims a register, and the granted write for that register clears
//   the entry.
//
// Ports
//   clk, rst             rising-edge clock, async active-high reset
//   req_valid/req_ready  per-requester handshake (ready is combinational)
//   req_reg/req_data     packed per-requester dest reg (4b) and data (16b)
//   claim_valid/reg      issue-stage reservation of a destination register
//   WriteReg/DstReg/DstData  registered register-file write port
//   pending              scoreboard, bit r = write to r outstanding
//   grant_id             index of the last granted requester (registered)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREQ     = 2,
  parameter bit DISCARD0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_reg,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic                 claim_valid,
  input  logic [3:0]           claim_reg,
  output logic                 WriteReg,
  output logic [3:0]           DstReg,
  output logic [15:0]          DstData,
  output logic [15:0]          pending,
  output logic [1:0]           grant_id
);

  localparam logic [1:0] LAST = 2'(NREQ - 1);

  logic [1:0]  ptr_q, ptr_d;
  logic        wr_q;
  logic [3:0]  dst_reg_q;
  logic [15:0] dst_data_q;
  logic [15:0] pend_q, pend_d;
  logic [1:0]  gid_q;

  logic        xfer;
  logic [1:0]  gnt_idx;
  logic [3:0]  sel_reg;
  logic [15:0] sel_data;
  logic        drop;

  // Round-robin search: the outer loop walks ptr, ptr+1, ... and the inner
  // loop maps each position onto a constant requester index.
  always_comb begin
    xfer     = 1'b0;
    gnt_idx  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!xfer && req_valid[i] && ((int'(ptr_q) + k) % NREQ) == i) begin
          xfer     = 1'b1;
          gnt_idx  = i[1:0];
          sel_reg  = req_reg[4*i +: 4];
          sel_data = req_data[16*i +: 16];
        end
      end
    end
    // Ready must read 0 for the whole time reset is asserted.
    if (rst) xfer = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = xfer && (gnt_idx == i[1:0]);
  end

  assign drop  = DISCARD0 && (sel_reg == 4'd0);
  assign ptr_d = (gnt_idx == LAST) ? 2'd0 : gnt_idx + 2'd1;

  // Apply the clear before the claim so that a same-cycle claim wins.
  // Register 0 is never tracked when writes to it are discarded.
  always_comb begin
    pend_d = pend_q;
    if (xfer)        pend_d[sel_reg]   = 1'b0;
    if (claim_valid) pend_d[claim_reg] = 1'b1;
    if (DISCARD0)    pend_d[0]         = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      wr_q       <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
      pend_q     <= '0;
      gid_q      <= '0;
    end else begin
      pend_q <= pend_d;
      wr_q   <= xfer && !drop;
      if (xfer) begin
        ptr_q <= ptr_d;
        gid_q <= gnt_idx;
        // A discarded R0 write leaves the address/data bus untouched.
        if (!drop) begin
          dst_reg_q  <= sel_reg;
          dst_data_q <= sel_data;
        end
      end
    end
  end

  assign WriteReg = wr_q;
  assign DstReg   = dst_reg_q;
  assign DstData  = dst_data_q;
  assign pending  = pend_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int NREQ = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_reg;
  logic [16*NREQ-1:0] req_data;
  logic              claim_valid;
  logic [3:0]        claim_reg;
  logic              WriteReg;
  logic [3:0]        DstReg;
  logic [15:0]       DstData;
  logic [15:0]       pending;
  logic [1:0]        grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DISCARD0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .claim_valid(claim_valid), .claim_reg(claim_reg),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .pending(pending), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; registered outputs are sampled 1ns
  // after the rising edge, combinational ready 1ns after the falling edge.

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_reg = '0; req_data = '0;
    claim_valid = 1'b1; claim_reg = 4'd3;
    #2;
    n_cmp++; if (WriteReg !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", WriteReg); end
    n_cmp++; if (pending !== 16'h0) begin n_bad++; $display("FAIL reset_pending: got %h want 0000", pending); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_cmp++; if ({DstReg, DstData, grant_id} !== 22'h0) begin n_bad++; $display("FAIL reset_regs: got %h %h %h want 0", DstReg, DstData, grant_id); end
    @(posedge clk); #1;
    n_cmp++; if (pending !== 16'h0) begin n_bad++; $display("FAIL reset_hold_pending: got %h want 0000", pending); end
    @(negedge clk);
    req_valid = '0; claim_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01; req_reg[3:0] = 4'd5; req_data[15:0] = 16'hBEEF;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (WriteReg !== 1'b1) begin n_bad++; $display("FAIL single_wr: got %b want 1", WriteReg); end
    n_cmp++; if (DstReg !== 4'd5) begin n_bad++; $display("FAIL single_reg: got %h want 5", DstReg); end
    n_cmp++; if (DstData !== 16'hBEEF) begin n_bad++; $display("FAIL single_data: got %h want beef", DstData); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL single_gid: got %0d want 0", grant_id); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if (WriteReg !== 1'b0) begin n_bad++; $display("FAIL single_idle_wr: got %b want 0", WriteReg); end
    n_cmp++; if (DstData !== 16'hBEEF) begin n_bad++; $display("FAIL single_idle_hold: got %h want beef", DstData); end
  endtask

  // ptr is 1 here, so requester 1 wins; after it, ptr wraps to 0.
  task automatic test_r0_discard();
    @(negedge clk);
    req_valid = 2'b10; req_reg[7:4] = 4'd0; req_data[31:16] = 16'h1234;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL r0_ready: got %b want 10", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (WriteReg !== 1'b0) begin n_bad++; $display("FAIL r0_wr: got %b want 0", WriteReg); end
    n_cmp++; if (pending[0] !== 1'b0) begin n_bad++; $display("FAIL r0_pending: got %b want 0", pending[0]); end
    @(negedge clk);
    req_valid = 2'b11; req_reg = {4'd2, 4'd1}; req_data = {16'h2222, 16'h1111};
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL r0_ptr_advanced: got %b want 01", req_ready); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0] exp_reg [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    logic [15:0] exp_dat [4] = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    logic [1:0] exp_gid [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    // Both requesters are already valid, and ptr is 0.
    for (int c = 0; c < 4; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      n_cmp++; if (req_ready !== exp_rdy[c]) begin n_bad++; $display("FAIL cont_ready[%0d]: got %b want %b", c, req_ready, exp_rdy[c]); end
      n_cmp++; if ($countones(req_ready) > 1) begin n_bad++; $display("FAIL cont_onehot[%0d]: got %b want at most one bit", c, req_ready); end
      @(posedge clk); #1;
      n_cmp++; if (grant_id !== exp_gid[c]) begin n_bad++; $display("FAIL cont_gid[%0d]: got %0d want %0d", c, grant_id, exp_gid[c]); end
      n_cmp++; if ({WriteReg, DstReg, DstData} !== {1'b1, exp_reg[c], exp_dat[c]}) begin n_bad++; $display("FAIL cont_write[%0d]: got %b %h %h want 1 %h %h", c, WriteReg, DstReg, DstData, exp_reg[c], exp_dat[c]); end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  // ptr is 0 on entry.
  task automatic test_scoreboard();
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 4'd3;
    @(posedge clk); #1;
    n_cmp++; if (pending !== 16'h0008) begin n_bad++; $display("FAIL sb_claim: got %h want 0008", pending); end
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 4'd3;
    req_valid = 2'b01; req_reg[3:0] = 4'd3; req_data[15:0] = 16'h3333;
    @(posedge clk); #1;
    n_cmp++; if (pending !== 16'h0008) begin n_bad++; $display("FAIL sb_claim_wins: got %h want 0008", pending); end
    n_cmp++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd3, 16'h3333}) begin n_bad++; $display("FAIL sb_write: got %b %h %h want 1 3 3333", WriteReg, DstReg, DstData); end
    // Requester 1 clears R3, and a claim of R0 must not mark it pending.
    @(negedge clk);
    claim_valid = 1'b1; claim_reg = 4'd0;
    req_valid = 2'b10; req_reg[7:4] = 4'd3; req_data[31:16] = 16'h3030;
    @(posedge clk); #1;
    n_cmp++; if (pending !== 16'h0000) begin n_bad++; $display("FAIL sb_clear: got %h want 0000", pending); end
    @(negedge clk);
    claim_valid = 1'b0; req_valid = '0;
  endtask

  task automatic test_back_to_back();
    // Requester 0 requests on every cycle. A grant to 0 always leaves ptr at 1,
    // so requester 1 wins as soon as it raises valid.
    @(negedge clk);
    req_valid = 2'b01; req_reg[3:0] = 4'd4; req_data[15:0] = 16'h4444;
    @(posedge clk); #1;
    n_cmp++; if (DstReg !== 4'd4) begin n_bad++; $display("FAIL b2b_first: got %h want 4", DstReg); end
    @(negedge clk);
    req_valid = 2'b11; req_reg[7:4] = 4'd9; req_data[31:16] = 16'hCAFE;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL b2b_ready1: got %b want 10", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if ({WriteReg, DstReg, DstData, grant_id} !== {1'b1, 4'd9, 16'hCAFE, 2'd1}) begin n_bad++; $display("FAIL b2b_write1: got %b %h %h %0d want 1 9 cafe 1", WriteReg, DstReg, DstData, grant_id); end
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL b2b_back0: got %b want 01", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if ({DstReg, DstData, grant_id} !== {4'd4, 16'h4444, 2'd0}) begin n_bad++; $display("FAIL b2b_write0: got %h %h %0d want 4 4444 0", DstReg, DstData, grant_id); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_midcycle();
    @(negedge clk);
    req_valid = 2'b01; req_reg[3:0] = 4'd6; req_data[15:0] = 16'h6666;
    claim_valid = 1'b1; claim_reg = 4'd8;
    @(posedge clk); #1;
    n_cmp++; if ({WriteReg, pending} !== {1'b1, 16'h0100}) begin n_bad++; $display("FAIL mid_pre: got %b %h want 1 0100", WriteReg, pending); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (WriteReg !== 1'b0) begin n_bad++; $display("FAIL mid_wr: got %b want 0", WriteReg); end
    n_cmp++; if (pending !== 16'h0) begin n_bad++; $display("FAIL mid_pending: got %h want 0000", pending); end
    n_cmp++; if ({DstReg, DstData, grant_id, req_ready} !== 24'h0) begin n_bad++; $display("FAIL mid_outs: got %h %h %0d %b want 0", DstReg, DstData, grant_id, req_ready); end
    @(negedge clk);
    rst = 1'b0; claim_valid = 1'b0;
    req_valid = 2'b11; req_reg[7:4] = 4'd7;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_ptr_reset: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_r0_discard();
    test_contention();
    test_scoreboard();
    test_back_to_back();
    test_reset_midcycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
